sr_frame_sequencer: RTL

//  Frame-level controller for the CORDIC -> sort chain -> DBSCAN -> MLP classification pipeline.

---
 rtl/sr_frame_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/sr_frame_sequencer.sv
// Frame-level controller for the CORDIC -> sort -> DBSCAN -> MLP pipeline.
// Streams exactly N samples per frame into the datapath and returns one result per frame.
module sr_frame_sequencer #(
    parameter int N       = 1000,
    parameter int CNT_W   = 10,
    parameter int CLR_CYC = 4,
    parameter int TIMEOUT = 8192,
    parameter int TO_W    = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [13:0] s_i,
    input  logic [13:0] s_q,
    output logic [13:0] dp_ini,
    output logic [13:0] dp_inq,
    output logic        dp_start,
    output logic        dp_rst_n,
    input  logic        dp_final,
    input  logic        mlp_done,
    input  logic [3:0]  mlp_class,
    input  logic [23:0] mlp_regr,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_class,
    output logic [23:0] res_regr,
    output logic [1:0]  res_err,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLASS = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    localparam int               CLR_W    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic [CLR_W-1:0]  clr_cnt_r;

    logic              accept_s;
    logic              started_s;
    logic              timeout_s;
    logic              res_load_s;
    logic [3:0]        res_class_s;
    logic [23:0]       res_regr_s;
    logic [1:0]        res_err_s;

    assign accept_s  = s_valid && (state_r == ST_LOAD);
    assign started_s = (cnt_r != {CNT_W{1'b0}});
    assign timeout_s = (to_cnt_r == TO_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and result-capture decode; a completed MLP result beats a same-cycle timeout
    always_comb begin
        state_s     = state_r;
        res_load_s  = 1'b0;
        res_class_s = 4'd0;
        res_regr_s  = 24'd0;
        res_err_s   = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_r == CLR_LAST) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else if (started_s) begin
                    state_s    = ST_HOLD;
                    res_load_s = 1'b1;
                    res_err_s  = 2'b10;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (dp_final && mlp_done) begin
                    state_s     = ST_HOLD;
                    res_load_s  = 1'b1;
                    res_class_s = mlp_class;
                    res_regr_s  = mlp_regr;
                end else if (timeout_s) begin
                    state_s    = ST_HOLD;
                    res_load_s = 1'b1;
                    res_err_s  = 2'b01;
                end else if (dp_final) begin
                    state_s = ST_CLASS;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_CLASS: begin
                if (mlp_done) begin
                    state_s     = ST_HOLD;
                    res_load_s  = 1'b1;
                    res_class_s = mlp_class;
                    res_regr_s  = mlp_regr;
                end else if (timeout_s) begin
                    state_s    = ST_HOLD;
                    res_load_s = 1'b1;
                    res_err_s  = 2'b01;
                end else begin
                    state_s = ST_CLASS;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    if (enable) begin
                        state_s = ST_CLEAR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sample, timeout and clear counters, each zeroed outside its own state(s)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
            clr_cnt_r <= {CLR_W{1'b0}};
        end else begin
            if (state_r != ST_LOAD) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (accept_s && (cnt_r != CNT_LAST)) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == ST_DRAIN) || (state_r == ST_CLASS)) begin
                to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
            if (state_r == ST_CLEAR) begin
                clr_cnt_r <= clr_cnt_r + {{(CLR_W-1){1'b0}}, 1'b1};
            end else begin
                clr_cnt_r <= {CLR_W{1'b0}};
            end
        end
    end

    // Registered control outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_ready   <= 1'b0;
            dp_rst_n  <= 1'b0;
            dp_start  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            s_ready   <= (state_s == ST_LOAD);
            dp_rst_n  <= (state_s != ST_IDLE) && (state_s != ST_CLEAR);
            dp_start  <= ((state_s == ST_LOAD) && (started_s || accept_s)) ||
                         (state_s == ST_DRAIN) || (state_s == ST_CLASS);
            res_valid <= (state_s == ST_HOLD);
            busy      <= (state_s != ST_IDLE);
        end
    end

    // Sample pipeline register and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_ini    <= 14'd0;
            dp_inq    <= 14'd0;
            res_class <= 4'd0;
            res_regr  <= 24'd0;
            res_err   <= 2'b00;
            frame_cnt <= 16'd0;
        end else begin
            if (accept_s) begin
                dp_ini <= s_i;
                dp_inq <= s_q;
            end else begin
                dp_ini <= dp_ini;
                dp_inq <= dp_inq;
            end
            if (res_load_s) begin
                res_class <= res_class_s;
                res_regr  <= res_regr_s;
                res_err   <= res_err_s;
            end else begin
                res_class <= res_class;
                res_regr  <= res_regr;
                res_err   <= res_err;
            end
            if ((state_r == ST_HOLD) && res_ready) begin
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end

endmodule
